sram_arbiter_2p: RTL and testbench
==================================

SRAM_ARBITER_2P -- requirements
Module: sram_arbiter_2p

Interface
REQ-001 Parameter TIMEOUT_CYC, default 15: WAIT cycles without i_mem_ack before the arbiter aborts with an error.
REQ-002 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 i_reset  in  1  synchronous, active-high reset.
REQ-004 i_m0_req / i_m1_req  in  1  master request; held high with stable fields until that master's ack.
REQ-005 i_m0_we / i_m1_we  in  1  1 = write, 0 = read.
REQ-006 i_m0_addr / i_m1_addr  in  18  SRAM halfword address, passed through unmodified.
REQ-007 i_m0_wdata / i_m1_wdata  in  32  write data.
REQ-008 i_m0_bmask / i_m1_bmask  in  4  byte mask.
REQ-009 o_m0_ack / o_m1_ack  out  1  one-cycle completion pulse.
REQ-010 o_m0_rdata / o_m1_rdata  out  32  read data, valid while that master's ack is high.
REQ-011 o_m0_err / o_m1_err  out  1  timeout flag, valid with ack.
REQ-012 o_mem_addr, o_mem_wdata, o_mem_bmask  out  18/32/4  registered copy of the granted request.
REQ-013 o_mem_wren / o_mem_rden  out  1  one-cycle command pulse to the SRAM controller.
REQ-014 i_mem_rdata  in  32  controller read data; i_mem_ack  in  1  controller completion pulse.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-016 IDLE: if any req is high, latch the winner's we/addr/wdata/bmask and its id, then go to ISSUE; otherwise stay in IDLE.
REQ-017 Arbitration is round-robin: a lone requester wins; if both request, the master not granted last wins.
REQ-018 ISSUE lasts exactly one cycle and drives o_mem_wren=we or o_mem_rden=~we; it then goes to WAIT.
REQ-019 o_mem_wren and o_mem_rden are never both high and are low in every state except ISSUE.
REQ-020 WAIT: on i_mem_ack, capture i_mem_rdata (reads only; 0 for writes), clear err, and go to RESP.
REQ-021 WAIT: the timeout counter starts at 0 on WAIT entry; when it reaches TIMEOUT_CYC without ack, set err=1, set rdata=0 and go to RESP.
REQ-022 RESP lasts one cycle, pulses ack, rdata and err to the granted master only, updates the last-grant pointer, and returns to IDLE.
REQ-023 Requests are not sampled in RESP; the acked master's req is required low by the following IDLE cycle.
REQ-024 i_mem_ack outside WAIT, including a late ack after a timeout, is ignored.
REQ-025 Latency from req high in IDLE (cycle 0) to master ack is 4 cycles for a write and 5 cycles for a read, given 2-cycle and 3-cycle controller ack after the command pulse.
REQ-026 Non-granted outputs o_mX_rdata and o_mX_err read 0 and their ack stays 0.

Reset
REQ-027 On i_reset, state returns to IDLE, even mid-transaction; the in-flight transaction is dropped with no ack.
REQ-028 Reset values: all o_* outputs 0, timeout counter 0, last-grant pointer = m1, so m0 wins the first tie.

Structure
REQ-029 Package sram_arb_pkg holds the state enum, the default TIMEOUT_CYC and the request-struct typedef (we, addr, wdata, bmask).
REQ-030 One sub-module, rr_arb2: combinational two-way round-robin pick from two requests and the last-grant pointer, returning a one-hot grant.

Verification
REQ-031 Reset, then m0 writes addr=0x00010, wdata=0xDEADBEEF, bmask=0xF -> o_mem_wren pulses in cycle 1, o_m0_ack in cycle 4, err=0.
REQ-032 m1 reads addr=0x00010 after REQ-031 -> o_mem_rden pulses once, o_m1_ack in cycle 5 with o_m1_rdata=0xDEADBEEF.
REQ-033 m0 and m1 request in the same cycle right after reset -> m0 served first; m1 is then granted in the IDLE cycle after m0's ack, with no idle gap beyond that IDLE.
REQ-034 Mem model withholds ack -> master ack with err=1 and rdata=0 exactly TIMEOUT_CYC cycles after WAIT entry; a later stray i_mem_ack produces no ack.
REQ-035 i_reset asserted during WAIT of a read -> next cycle state is IDLE, all outputs 0, and no ack to either master.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

    localparam int unsigned TIMEOUT_CYC_DEFAULT = 15;

    localparam int unsigned ADDR_W = 18;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] bmask;
    } mem_req_t;

    // Bundle one master's request fields into the latched request record.
    function automatic mem_req_t pack_req(
        input logic              we,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata,
        input logic [MASK_W-1:0] bmask
    );
        mem_req_t r;
        r.we    = we;
        r.addr  = addr;
        r.wdata = wdata;
        r.bmask = bmask;
        return r;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// master that was not granted last. Grant is one-hot (or zero when idle).
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // Combinational pick from requests and last-grant pointer.
    always_comb begin
        gnt_o = '0;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
            default: gnt_o = '0;
        endcase
    end

endmodule

// File: rtl/sram_arbiter_2p.sv
// Two-master SRAM arbiter: round-robin grant, one-cycle command pulse to the
// SRAM controller, bounded wait for the controller ack, one-cycle response.
module sram_arbiter_2p
    import sram_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_m0_req,
    input  logic        i_m0_we,
    input  logic [17:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    input  logic [3:0]  i_m0_bmask,
    output logic        o_m0_ack,
    output logic [31:0] o_m0_rdata,
    output logic        o_m0_err,

    input  logic        i_m1_req,
    input  logic        i_m1_we,
    input  logic [17:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    input  logic [3:0]  i_m1_bmask,
    output logic        o_m1_ack,
    output logic [31:0] o_m1_rdata,
    output logic        o_m1_err,

    output logic [17:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    output logic        o_mem_wren,
    output logic        o_mem_rden,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack
);

    // The counter only has to reach TIMEOUT_CYC-1: the WAIT cycle that sees
    // that value is the last one, so the response lands exactly TIMEOUT_CYC
    // cycles after WAIT entry.
    localparam int unsigned       CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_t        state_q, state_d;
    mem_req_t          req_q,   req_d;
    logic              id_q,    id_d;      // granted master: 0 = m0, 1 = m1
    logic              last_q,  last_d;    // master granted last
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q,   err_d;

    logic [1:0]        gnt;
    mem_req_t          m0_req_s;
    mem_req_t          m1_req_s;
    logic              resp_m0;
    logic              resp_m1;

    rr_arb2 u_rr_arb2 (
        .req_i  ({i_m1_req, i_m0_req}),
        .last_i (last_q),
        .gnt_o  (gnt)
    );

    // Gather each master's request fields into one record.
    always_comb begin
        m0_req_s = pack_req(i_m0_we, i_m0_addr, i_m0_wdata, i_m0_bmask);
        m1_req_s = pack_req(i_m1_we, i_m1_addr, i_m1_wdata, i_m1_bmask);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            id_q    <= id_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: grant, issue, wait with timeout, respond.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        id_d    = id_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt[0] || gnt[1]) begin
                    req_d   = gnt[1] ? m1_req_s : m0_req_s;
                    id_d    = gnt[1];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_mem_ack) begin
                    rdata_d = req_q.we ? '0 : i_mem_rdata;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                last_d  = id_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: command pulse in ISSUE, response routed to the granted master only.
    always_comb begin
        o_mem_addr  = req_q.addr;
        o_mem_wdata = req_q.wdata;
        o_mem_bmask = req_q.bmask;
        o_mem_wren  = (state_q == ST_ISSUE) &&  req_q.we;
        o_mem_rden  = (state_q == ST_ISSUE) && !req_q.we;

        resp_m0     = (state_q == ST_RESP) && !id_q;
        resp_m1     = (state_q == ST_RESP) &&  id_q;

        o_m0_ack    = resp_m0;
        o_m0_rdata  = resp_m0 ? rdata_q : '0;
        o_m0_err    = resp_m0 && err_q;
        o_m1_ack    = resp_m1;
        o_m1_rdata  = resp_m1 ? rdata_q : '0;
        o_m1_err    = resp_m1 && err_q;
    end

    // Structural invariants of the command and response pulses.
    a_cmd_excl: assert property (@(posedge i_clk) disable iff (i_reset)
        !(o_mem_wren && o_mem_rden));
    a_ack_excl: assert property (@(posedge i_clk) disable iff (i_reset)
        !(o_m0_ack && o_m1_ack));

endmodule

// File: tb/tb_sram_arbiter_2p.sv
// Directed bench for sram_arbiter_2p with a transaction-level reference model
// and an SRAM controller model with configurable ack latency.
module tb_sram_arbiter_2p;

    localparam int TO = 15;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_m0_req, i_m0_we, i_m1_req, i_m1_we;
    logic [17:0] i_m0_addr, i_m1_addr;
    logic [31:0] i_m0_wdata, i_m1_wdata;
    logic [3:0]  i_m0_bmask, i_m1_bmask;
    logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
    logic [31:0] o_m0_rdata, o_m1_rdata;
    logic [17:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        o_mem_wren, o_mem_rden;
    logic [31:0] i_mem_rdata;
    logic        i_mem_ack;

    sram_arbiter_2p #(.TIMEOUT_CYC(TO)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_m0_req   (i_m0_req),
        .i_m0_we    (i_m0_we),
        .i_m0_addr  (i_m0_addr),
        .i_m0_wdata (i_m0_wdata),
        .i_m0_bmask (i_m0_bmask),
        .o_m0_ack   (o_m0_ack),
        .o_m0_rdata (o_m0_rdata),
        .o_m0_err   (o_m0_err),
        .i_m1_req   (i_m1_req),
        .i_m1_we    (i_m1_we),
        .i_m1_addr  (i_m1_addr),
        .i_m1_wdata (i_m1_wdata),
        .i_m1_bmask (i_m1_bmask),
        .o_m1_ack   (o_m1_ack),
        .o_m1_rdata (o_m1_rdata),
        .o_m1_err   (o_m1_err),
        .o_mem_addr (o_mem_addr),
        .o_mem_wdata(o_mem_wdata),
        .o_mem_bmask(o_mem_bmask),
        .o_mem_wren (o_mem_wren),
        .o_mem_rden (o_mem_rden),
        .i_mem_rdata(i_mem_rdata),
        .i_mem_ack  (i_mem_ack)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // ---------------- memories: SRAM model contents and reference shadow
    logic [31:0] sram   [logic [17:0]];
    logic [31:0] shadow [logic [17:0]];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] bm);
        logic [31:0] v;
        v = old;
        for (int b = 0; b < 4; b++) if (bm[b]) v[8*b +: 8] = wd[8*b +: 8];
        return v;
    endfunction

    function automatic logic [31:0] sram_rd(input logic [17:0] a);
        return sram.exists(a) ? sram[a] : 32'h0;
    endfunction

    function automatic logic [31:0] shadow_rd(input logic [17:0] a);
        return shadow.exists(a) ? shadow[a] : 32'h0;
    endfunction

    // ---------------- SRAM controller model: ack mem_lat cycles after the command (0 = never)
    int          mem_lat = 2;
    int          mm_l;
    logic        mm_w;
    logic [17:0] mm_addr;
    logic [31:0] mm_wdata;
    logic [3:0]  mm_bmask;

    initial begin
        i_mem_ack   = 1'b0;
        i_mem_rdata = '0;
        forever begin
            @(negedge i_clk);
            if (o_mem_wren === 1'b1 || o_mem_rden === 1'b1) begin
                mm_l     = mem_lat;
                mm_w     = o_mem_wren;
                mm_addr  = o_mem_addr;
                mm_wdata = o_mem_wdata;
                mm_bmask = o_mem_bmask;
                if (mm_l > 0) begin
                    repeat (mm_l) @(posedge i_clk);
                    #1;
                    if (mm_w) sram[mm_addr] = merge(sram_rd(mm_addr), mm_wdata, mm_bmask);
                    i_mem_rdata = mm_w ? 32'hBAD0_F00D : sram_rd(mm_addr);
                    i_mem_ack   = 1'b1;
                    @(posedge i_clk);
                    #1;
                    i_mem_ack   = 1'b0;
                    i_mem_rdata = '0;
                end
            end
        end
    end

    // ---------------- reference model: transaction timeline in cycle numbers
    int          cyc = 0;
    bit          m_valid = 0, m_busy = 0, m_we = 0, m_err = 0;
    int          m_id = 0, m_last = 1, m_g = 0, m_resp = 0, m_idle_from = 0, m_l;
    logic [31:0] m_rdata = '0;
    logic [17:0] e_addr = '0;
    logic [31:0] e_wdata = '0;
    logic [3:0]  e_bmask = '0;
    bit          s_rst, s_r0, s_r1, ok_lat, in_cmd, in_resp;

    initial begin
        forever begin
            @(posedge i_clk);
            s_rst = i_reset;
            s_r0  = i_m0_req;
            s_r1  = i_m1_req;
            if (s_rst) begin
                m_valid = 1; m_busy = 0; m_last = 1;
                e_addr = '0; e_wdata = '0; e_bmask = '0;
                m_idle_from = cyc + 1;
            end else if (m_valid) begin
                if (m_busy && cyc == m_resp) m_busy = 0;
                if (!m_busy && cyc >= m_idle_from && (s_r0 || s_r1)) begin
                    m_id   = (s_r0 && s_r1) ? 1 - m_last : (s_r1 ? 1 : 0);
                    m_last = m_id;
                    m_we   = (m_id == 0) ? i_m0_we    : i_m1_we;
                    e_addr = (m_id == 0) ? i_m0_addr  : i_m1_addr;
                    e_wdata= (m_id == 0) ? i_m0_wdata : i_m1_wdata;
                    e_bmask= (m_id == 0) ? i_m0_bmask : i_m1_bmask;
                    m_g    = cyc;
                    m_l    = mem_lat;
                    ok_lat = (m_l >= 1) && (m_l <= TO);
                    m_resp = ok_lat ? cyc + m_l + 2 : cyc + 2 + TO;
                    m_err  = !ok_lat;
                    m_rdata = (m_err || m_we) ? 32'h0 : shadow_rd(e_addr);
                    if (m_we && !m_err) shadow[e_addr] = merge(shadow_rd(e_addr), e_wdata, e_bmask);
                    m_idle_from = m_resp + 1;
                    m_busy = 1;
                end
            end
            cyc++;
            @(negedge i_clk);
            if (m_valid) begin
                in_cmd  = m_busy && (cyc == m_g + 1);
                in_resp = m_busy && (cyc == m_resp);
                chk("mem_wren",  o_mem_wren,  in_cmd && m_we);
                chk("mem_rden",  o_mem_rden,  in_cmd && !m_we);
                chk("mem_addr",  o_mem_addr,  e_addr);
                chk("mem_wdata", o_mem_wdata, e_wdata);
                chk("mem_bmask", o_mem_bmask, e_bmask);
                chk("m0_ack",    o_m0_ack,    in_resp && m_id == 0);
                chk("m1_ack",    o_m1_ack,    in_resp && m_id == 1);
                chk("m0_rdata",  o_m0_rdata,  (in_resp && m_id == 0) ? m_rdata : 32'h0);
                chk("m1_rdata",  o_m1_rdata,  (in_resp && m_id == 1) ? m_rdata : 32'h0);
                chk("m0_err",    o_m0_err,    in_resp && m_id == 0 && m_err);
                chk("m1_err",    o_m1_err,    in_resp && m_id == 1 && m_err);
            end
        end
    end

    // ---------------- master transaction: raise req, hold until ack, then drop
    task automatic do_txn(input int id, input logic we, input logic [17:0] addr,
                          input logic [31:0] wd, input logic [3:0] bm,
                          output int lat, output logic [31:0] rd, output logic er,
                          output int ck, output int cn);
        bit got;
        int k;
        got = 0; k = 0; lat = -1; rd = '0; er = 1'b0; ck = -1; cn = 0;
        @(posedge i_clk);
        #1;
        if (id == 0) begin
            i_m0_req = 1'b1; i_m0_we = we; i_m0_addr = addr; i_m0_wdata = wd; i_m0_bmask = bm;
        end else begin
            i_m1_req = 1'b1; i_m1_we = we; i_m1_addr = addr; i_m1_wdata = wd; i_m1_bmask = bm;
        end
        while (!got && k < 64) begin
            @(negedge i_clk);
            if (o_mem_wren || o_mem_rden) begin
                cn++;
                if (ck < 0) ck = k;
            end
            if ((id == 0 && o_m0_ack) || (id == 1 && o_m1_ack)) begin
                got = 1;
                lat = k;
                rd  = (id == 0) ? o_m0_rdata : o_m1_rdata;
                er  = (id == 0) ? o_m0_err   : o_m1_err;
            end
            k++;
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL txn_timeout m%0d: no ack after %0d cycles, required an ack", id, k);
        end
        @(posedge i_clk);
        #1;
        if (id == 0) begin
            i_m0_req = 1'b0; i_m0_we = 1'b0; i_m0_addr = '0; i_m0_wdata = '0; i_m0_bmask = '0;
        end else begin
            i_m1_req = 1'b0; i_m1_we = 1'b0; i_m1_addr = '0; i_m1_wdata = '0; i_m1_bmask = '0;
        end
    endtask

    task automatic pulse_reset();
        @(posedge i_clk);
        #1 i_reset = 1'b1;
        @(posedge i_clk);
        #1 i_reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m0_ack"},    o_m0_ack,    0);
        chk({tag, "_m1_ack"},    o_m1_ack,    0);
        chk({tag, "_m0_rdata"},  o_m0_rdata,  0);
        chk({tag, "_m1_rdata"},  o_m1_rdata,  0);
        chk({tag, "_m0_err"},    o_m0_err,    0);
        chk({tag, "_m1_err"},    o_m1_err,    0);
        chk({tag, "_mem_addr"},  o_mem_addr,  0);
        chk({tag, "_mem_wdata"}, o_mem_wdata, 0);
        chk({tag, "_mem_bmask"}, o_mem_bmask, 0);
        chk({tag, "_mem_wren"},  o_mem_wren,  0);
        chk({tag, "_mem_rden"},  o_mem_rden,  0);
    endtask

    int          la, lb, ca, cb, na, nb, acks;
    logic [31:0] ra, rb;
    logic        ea, eb;

    initial begin
        i_reset = 1'b1;
        i_m0_req = 1'b0; i_m0_we = 1'b0; i_m0_addr = '0; i_m0_wdata = '0; i_m0_bmask = '0;
        i_m1_req = 1'b0; i_m1_we = 1'b0; i_m1_addr = '0; i_m1_wdata = '0; i_m1_bmask = '0;
        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b0;
        @(negedge i_clk);
        chk_all_zero("reset");

        // m0 write: command in cycle 1, ack in cycle 4
        mem_lat = 2;
        do_txn(0, 1'b1, 18'h00010, 32'hDEADBEEF, 4'hF, la, ra, ea, ca, na);
        chk("wr_lat", la, 4);
        chk("wr_cmd_cycle", ca, 1);
        chk("wr_cmd_count", na, 1);
        chk("wr_err", ea, 0);
        chk("wr_rdata", ra, 0);

        // m1 read back: ack in cycle 5 with the written data
        mem_lat = 3;
        do_txn(1, 1'b0, 18'h00010, 32'h0, 4'h0, lb, rb, eb, cb, nb);
        chk("rd_lat", lb, 5);
        chk("rd_cmd_cycle", cb, 1);
        chk("rd_cmd_count", nb, 1);
        chk("rd_rdata", rb, 32'hDEADBEEF);
        chk("rd_err", eb, 0);

        // tie right after reset: m0 first, m1 granted in the IDLE cycle after m0's ack
        pulse_reset();
        fork
            do_txn(0, 1'b1, 18'h00020, 32'h12345678, 4'h3, la, ra, ea, ca, na);
            do_txn(1, 1'b0, 18'h00010, 32'h0, 4'h0, lb, rb, eb, cb, nb);
        join
        chk("tie_m0_lat", la, 5);
        chk("tie_m1_lat", lb, 11);
        chk("tie_m1_rdata", rb, 32'hDEADBEEF);

        // partial byte-mask write seen on read-back
        do_txn(1, 1'b0, 18'h00020, 32'h0, 4'h0, lb, rb, eb, cb, nb);
        chk("mask_rdata", rb, 32'h00005678);

        // after a lone m0 grant, a tie goes to m1
        do_txn(0, 1'b1, 18'h00030, 32'hCAFE0001, 4'hF, la, ra, ea, ca, na);
        chk("solo_m0_lat", la, 5);
        fork
            do_txn(0, 1'b0, 18'h00030, 32'h0, 4'h0, la, ra, ea, ca, na);
            do_txn(1, 1'b0, 18'h00020, 32'h0, 4'h0, lb, rb, eb, cb, nb);
        join
        chk("rr_m1_lat", lb, 5);
        chk("rr_m0_lat", la, 11);
        chk("rr_m0_rdata", ra, 32'hCAFE0001);

        // controller never acks: timeout TO cycles after WAIT entry (cycle 2)
        mem_lat = 0;
        do_txn(0, 1'b0, 18'h00030, 32'h0, 4'h0, la, ra, ea, ca, na);
        chk("to_lat", la, 2 + TO);
        chk("to_err", ea, 1);
        chk("to_rdata", ra, 0);

        // late stray ack is ignored
        @(posedge i_clk);
        #1 i_mem_ack = 1'b1; i_mem_rdata = 32'h55AA55AA;
        @(posedge i_clk);
        #1 i_mem_ack = 1'b0; i_mem_rdata = '0;
        acks = 0;
        repeat (4) begin
            @(negedge i_clk);
            acks += int'(o_m0_ack) + int'(o_m1_ack);
        end
        chk("stray_acks", acks, 0);

        // reset during WAIT of a read drops the transaction
        mem_lat = 5;
        @(posedge i_clk);
        #1 i_m1_req = 1'b1; i_m1_we = 1'b0; i_m1_addr = 18'h00010;
        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b1; i_m1_req = 1'b0; i_m1_addr = '0;
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        @(negedge i_clk);
        chk_all_zero("wait_reset");
        acks = 0;
        repeat (10) begin
            @(negedge i_clk);
            acks += int'(o_m0_ack) + int'(o_m1_ack);
        end
        chk("reset_drop_acks", acks, 0);

        // normal service resumes
        mem_lat = 3;
        do_txn(0, 1'b0, 18'h00020, 32'h0, 4'h0, la, ra, ea, ca, na);
        chk("recover_lat", la, 5);
        chk("recover_rdata", ra, 32'h00005678);

        repeat (3) @(negedge i_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
